// File: rtl/prog_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem_ctrl
// Description : Writable program store with a valid/ready load stream, a
//               registered pc-indexed fetch port, and run / halt / single-step
//               / breakpoint control delivered to the core as a clock enable.
//               Optional build macro PROG_CHECKSUM_EN adds a running
//               modulo-2**DATA_W checksum of the loaded words.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_mem_ctrl #(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] NOP    = '0
) (
  input  logic              origclk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len,
`ifdef PROG_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  input  logic              run,
  input  logic              step,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              cpu_en,
  output logic              halted,
  output logic              done
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_run  = 2'd2;
  localparam logic [1:0] c_st_halt = 2'd3;

  localparam int              c_len_w     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   c_depth     = c_len_w'(DEPTH);
  localparam logic [ADDR_W:0]   c_len_one   = c_len_w'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [DATA_W-1:0] instruction_q, instruction_d;
  logic              load_err_q, load_err_d;
  logic              done_q, done_d;
  logic              step_q;
  logic              resume_mask_q, resume_mask_d;
  logic [ADDR_W-1:0] pc_prev_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic w_beat;
  logic w_load_go;
  logic w_pc_in_prog;
  logic w_step_rise;
  logic w_bp_hit;

  assign w_beat       = (state_q == c_st_load) && load_valid;
  assign w_load_go    = load_start && (state_q != c_st_load);
  assign w_pc_in_prog = ({1'b0, pc} < prog_len_q);
  assign w_step_rise  = step && !step_q;
  // The mask suppresses the breakpoint that just halted us so that resuming
  // executes the breakpoint instruction once instead of re-halting on it.
  assign w_bp_hit     = bp_en && (pc == bp_addr) && !resume_mask_q;

  // State register
  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: load_start beats breakpoint/end, which beat run/step
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (load_start)                      state_d = c_st_load;
        else if (run && (prog_len_q != '0))  state_d = c_st_run;
      end
      c_st_load: begin
        if (w_beat && (load_last || (wr_ptr_q == c_last_addr))) state_d = c_st_idle;
      end
      c_st_run: begin
        if (load_start)                                 state_d = c_st_load;
        else if (w_bp_hit || !w_pc_in_prog || !run)     state_d = c_st_halt;
      end
      c_st_halt: begin
        if (load_start)            state_d = c_st_load;
        else if (run && !done_q)   state_d = c_st_run;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Outputs decoded from state; cpu_en is combinational so the core never
  // steps onto a breakpoint or past the end of the program
  always_comb begin
    load_ready = (state_q == c_st_load);
    halted     = (state_q == c_st_halt);
    cpu_en     = 1'b0;
    case (state_q)
      c_st_run:  cpu_en = !w_bp_hit && w_pc_in_prog;
      // A step edge coinciding with run=1 or load_start is absorbed
      c_st_halt: cpu_en = w_step_rise && !done_q && !run && !load_start;
      default:   cpu_en = 1'b0;
    endcase
  end

  // Load bookkeeping, status flags and breakpoint resume mask
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    prog_len_d    = prog_len_q;
    load_err_d    = load_err_q;
    done_d        = done_q;
    resume_mask_d = resume_mask_q;
    if (pc != pc_prev_q) begin
      resume_mask_d = 1'b0;
    end
    if (w_load_go) begin
      wr_ptr_d   = '0;
      load_err_d = 1'b0;
      done_d     = 1'b0;
    end
    if (w_beat) begin
      wr_ptr_d = wr_ptr_q + c_addr_one;
      if (load_last) begin
        prog_len_d = {1'b0, wr_ptr_q} + c_len_one;
      end else if (wr_ptr_q == c_last_addr) begin
        prog_len_d = c_depth;
        load_err_d = 1'b1;
      end
    end
    // Setting the mask wins over the pc-change clear in the same cycle
    if ((state_q == c_st_run) && !load_start) begin
      if (w_bp_hit)           resume_mask_d = 1'b1;
      else if (!w_pc_in_prog) done_d        = 1'b1;
    end
  end

  // Fetch word: NOP while loading or when pc is beyond the loaded program
  always_comb begin
    instruction_d = NOP;
    if ((state_q != c_st_load) && w_pc_in_prog) begin
      instruction_d = mem[pc];
    end
  end

  // Datapath registers
  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      instruction_q <= NOP;
      load_err_q    <= 1'b0;
      done_q        <= 1'b0;
      step_q        <= 1'b0;
      resume_mask_q <= 1'b0;
      pc_prev_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      prog_len_q    <= prog_len_d;
      instruction_q <= instruction_d;
      load_err_q    <= load_err_d;
      done_q        <= done_d;
      step_q        <= step;
      resume_mask_q <= resume_mask_d;
      pc_prev_q     <= pc;
    end
  end

  // Instruction store write port; contents survive reset
  always_ff @(posedge origclk) begin
    if (w_beat) begin
      mem[wr_ptr_q] <= load_data;
    end
  end

`ifdef PROG_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running sum of accepted beats, restarted when a new load is accepted
  always_comb begin
    checksum_d = checksum_q;
    if (w_load_go)   checksum_d = '0;
    else if (w_beat) checksum_d = checksum_q + load_data;
  end

  // Checksum register
  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

  assign prog_len    = prog_len_q;
  assign instruction = instruction_q;
  assign load_err    = load_err_q;
  assign done        = done_q;

endmodule
`default_nettype wire
